// File: rtl/change_dispenser_if.sv
// Signal bundle between the vending controller / coin hopper (master) and the
// change dispenser (slave).
interface change_dispenser_if #(
   parameter int AMT_W = 5,
   parameter int INV_W = 6
);
   logic             req;
   logic [AMT_W-1:0] amt;
   logic             ack;
   logic             refill;
   logic [1:0]       refill_sel;
   logic             drop_n;
   logic             drop_d;
   logic             drop_q;
   logic             busy;
   logic             done;
   logic             short;
   logic             fault;
   logic [AMT_W-1:0] remaining;
   logic [INV_W-1:0] inv_q;
   logic [INV_W-1:0] inv_d;
   logic [INV_W-1:0] inv_n;

   modport master (
      output req, amt, ack, refill, refill_sel,
      input  drop_n, drop_d, drop_q, busy, done, short, fault, remaining,
             inv_q, inv_d, inv_n
   );

   modport slave (
      input  req, amt, ack, refill, refill_sel,
      output drop_n, drop_d, drop_q, busy, done, short, fault, remaining,
             inv_q, inv_d, inv_n
   );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change payout: one coin per hopper handshake, largest coin first,
// with per-coin inventory tracking and a hopper-ack timeout.
module change_dispenser #(
   parameter int AMT_W   = 5,
   parameter int INV_W   = 6,
   parameter int INIT_Q  = 8,
   parameter int INIT_D  = 8,
   parameter int INIT_N  = 8,
   parameter int TIMEOUT = 16
) (
   input logic               clk,
   input logic               reset,
   change_dispenser_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SELECT, DROP, FINISH} state_t;

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   // coin index 0/1/2 = nickel/dime/quarter, matching refill_sel encoding
   localparam logic [2:0][AMT_W-1:0] COIN_VAL = {AMT_W'(5), AMT_W'(2), AMT_W'(1)};
   localparam logic [2:0][INV_W-1:0] INV_INIT = {INV_W'(INIT_Q), INV_W'(INIT_D), INV_W'(INIT_N)};
   localparam logic [INV_W-1:0]      INV_MAX  = '1;

   state_t                 state, state_nx;
   logic [CNT_W-1:0]       cnt;
   logic [2:0]             drop;
   logic [2:0]             pick;
   logic [2:0][INV_W-1:0]  inv;
   logic [AMT_W-1:0]       remaining;
   logic [AMT_W-1:0]       drop_val;
   logic                   short_r, fault_r;
   logic                   accept, give, expire, none, paid;

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      pick     = 3'b000;
      accept   = 1'b0;
      give     = 1'b0;
      expire   = 1'b0;
      none     = 1'b0;
      paid     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req) begin
               accept   = 1'b1;
               state_nx = (bus.amt == '0) ? FINISH : SELECT;
            end
         end
         SELECT: begin
            if (remaining == '0) begin
               paid     = 1'b1;
               state_nx = FINISH;
            end else if (COIN_VAL[2] <= remaining && inv[2] != '0) begin
               pick     = 3'b100;
               state_nx = DROP;
            end else if (COIN_VAL[1] <= remaining && inv[1] != '0) begin
               pick     = 3'b010;
               state_nx = DROP;
            end else if (COIN_VAL[0] <= remaining && inv[0] != '0) begin
               pick     = 3'b001;
               state_nx = DROP;
            end else begin
               none     = 1'b1;
               state_nx = FINISH;
            end
         end
         DROP: begin
            // an ack on the final counted cycle still wins over the timeout
            if (bus.ack) begin
               give     = 1'b1;
               state_nx = SELECT;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               expire   = 1'b1;
               state_nx = FINISH;
            end
         end
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      drop_val = '0;
      for (int i = 0; i < 3; i++)
         if (drop[i]) drop_val = COIN_VAL[i];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         drop      <= 3'b000;
         cnt       <= '0;
         remaining <= '0;
         short_r   <= 1'b0;
         fault_r   <= 1'b0;
      end else begin
         if (pick != 3'b000)      drop <= pick;
         else if (give || expire) drop <= 3'b000;

         if (state == DROP && !give && !expire) cnt <= cnt + 1'b1;
         else                                   cnt <= '0;

         if (accept)    remaining <= bus.amt;
         else if (give) remaining <= remaining - drop_val;

         if (accept || paid)      short_r <= 1'b0;
         else if (none || expire) short_r <= 1'b1;

         if (accept)      fault_r <= 1'b0;
         else if (expire) fault_r <= 1'b1;
      end
   end

   for (genvar i = 0; i < 3; i++) begin : g_inv
      logic             inc, dec;
      logic [INV_W-1:0] count;

      assign inc = bus.refill && (bus.refill_sel == 2'(i));
      assign dec = give && drop[i];

      // simultaneous refill and payout of the same coin cancel out
      always_ff @(posedge clk) begin
         if (!reset)                        count <= INV_INIT[i];
         else if (inc && !dec && count != INV_MAX) count <= count + 1'b1;
         else if (dec && !inc)              count <= count - 1'b1;
      end

      assign inv[i] = count;
   end

   assign bus.drop_n    = drop[0];
   assign bus.drop_d    = drop[1];
   assign bus.drop_q    = drop[2];
   assign bus.busy      = (state != IDLE);
   assign bus.done      = (state == FINISH);
   assign bus.short     = short_r;
   assign bus.fault     = fault_r;
   assign bus.remaining = remaining;
   assign bus.inv_n     = inv[0];
   assign bus.inv_d     = inv[1];
   assign bus.inv_q     = inv[2];
endmodule
